// File: rtl/rs232_txb_if.sv
// Host-side port bundle of the buffered RS232 transmitter: byte writes in,
// serial line and FIFO status out.
interface rs232_txb_if;
    logic       fsel;
    logic       wr;
    logic [7:0] data_in;
    logic       txd;
    logic       empty;
    logic       full;
    logic       idle;

    modport master (output fsel, wr, data_in, input txd, empty, full, idle);
    modport slave  (input fsel, wr, data_in, output txd, empty, full, idle);
endinterface

// File: rtl/rs232_txb.sv
// Buffered 8N1 transmitter: byte FIFO with single-cycle writes, drained by a
// bit-serial engine that chains frames back-to-back while bytes are queued.
module rs232_txb #(
    parameter int clock_freq = 50000000,
    parameter int num_slots  = 63
) (
    input  logic        clk,
    input  logic        rst,
    rs232_txb_if.slave  bus
);
    localparam int DIV_FAST = clock_freq / 115200;
    localparam int DIV_SLOW = clock_freq / 19200;
    localparam int DIV_MAX  = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int TW       = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int PW       = (num_slots > 1) ? $clog2(num_slots) : 1;
    localparam int CW       = $clog2(num_slots + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [num_slots];
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            empty_r, full_r;
    logic            push, pop;
    logic [9:0]      frame;
    logic [TW-1:0]   tick, div_m1;
    logic [3:0]      bitcnt;
    logic            sel_fast;
    logic            bit_end;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(num_slots - 1)) ? '0 : p + 1'b1;
    endfunction

    // full is the registered flag, so a pop in the same cycle never makes room
    assign push    = bus.wr && !full_r;
    assign div_m1  = sel_fast ? TW'(DIV_FAST - 1) : TW'(DIV_SLOW - 1);
    assign bit_end = (state == SHIFT) && (tick == div_m1);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_r) begin
                    pop       = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_end && bitcnt == 4'd9) begin
                    if (!empty_r) pop = 1'b1;
                    else          state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)      cnt_nxt = cnt + 1'b1;
        else if (!push && pop) cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            cnt     <= cnt_nxt;
            empty_r <= (cnt_nxt == '0);
            full_r  <= (cnt_nxt == CW'(num_slots));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wptr] <= bus.data_in;
    end

    // Rate select is latched per frame so fsel changes only apply at the next load
    always_ff @(posedge clk) begin
        if (rst) begin
            frame    <= '1;
            tick     <= '0;
            bitcnt   <= '0;
            sel_fast <= 1'b0;
        end else if (pop) begin
            frame    <= {1'b1, mem[rptr], 1'b0};
            tick     <= '0;
            bitcnt   <= '0;
            sel_fast <= bus.fsel;
        end else if (state == SHIFT) begin
            if (bit_end) begin
                tick   <= '0;
                frame  <= {1'b1, frame[9:1]};
                bitcnt <= bitcnt + 4'd1;
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

    assign bus.txd   = (state == SHIFT) ? frame[0] : 1'b1;
    assign bus.empty = empty_r;
    assign bus.full  = full_r;
    assign bus.idle  = (state == IDLE) && empty_r;
endmodule
